// File: rtl/switches_poll_pkg.sv
// Shared types and constants for the switches PIO poller.
package switches_poll_pkg;

  typedef enum logic [1:0] {IDLE, READ, WAIT, EVAL} poll_state_e;

  localparam logic [31:0] PIO_DATA_ADDR = 32'd0;

endpackage

// File: rtl/poll_tick_div.sv
// Poll-rate divider: counts idle cycles while running and flags the last one.
module poll_tick_div #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic count_en,
  output logic tick
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = run && count_en && (cnt == CNT_W'(POLL_DIV - 1));

  // Dropping run parks the count at zero so a re-enable waits a full period.
  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switches_poll_ctrl.sv
// Avalon-MM read master polling the switches PIO, debouncing samples and
// publishing stable changes as valid/ready events with sticky overrun.
module switches_poll_ctrl
  import switches_poll_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 2,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sw_value,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic              evt_overrun,
  input  logic              clr_overrun
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  poll_state_e       state;
  logic              tick;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] next_cand;
  logic [CNT_W-1:0]  stab_cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic              fire;
  logic              overrun_set;
  logic              unused_readdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(STABLE_CNT)) ? CNT_W'(STABLE_CNT) : c + CNT_W'(1);
  endfunction

  assign avm_address     = ADDR_W'(PIO_DATA_ADDR);
  assign unused_readdata = ^avm_readdata[31:DATA_W];

  poll_tick_div #(
    .POLL_DIV (POLL_DIV)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (enable),
    .count_en (state == IDLE),
    .tick     (tick)
  );

  // Debounce outcome of the captured sample, committed only in EVAL.
  always_comb begin
    next_cand = cand;
    next_cnt  = stab_cnt;
    if (sample == cand) begin
      next_cnt = sat_inc(stab_cnt);
    end else begin
      next_cand = sample;
      next_cnt  = CNT_W'(1);
    end
    fire        = (state == EVAL) && (next_cnt == CNT_W'(STABLE_CNT)) &&
                  (next_cand != sw_value);
    overrun_set = fire && evt_valid && !evt_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      lat_cnt     <= '0;
      sample      <= '0;
      cand        <= '0;
      stab_cnt    <= '0;
      sw_value    <= '0;
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= READ;
            avm_read <= 1'b1;
          end
        end
        READ: begin
          avm_read <= 1'b0;
          lat_cnt  <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            sample <= avm_readdata[DATA_W-1:0];
            state  <= EVAL;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        EVAL: begin
          cand     <= next_cand;
          stab_cnt <= next_cnt;
          if (fire) begin
            sw_value <= next_cand;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // An accepted event is replaced rather than flagged when a new one lands.
      if (fire) begin
        evt_data  <= next_cand;
        evt_valid <= 1'b1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (overrun_set) begin
        evt_overrun <= 1'b1;
      end else if (clr_overrun) begin
        evt_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switches_poll_ctrl.sv
// Bench for switches_poll_ctrl: directed vector table, corner sequences and
// randomized traffic scored against a transaction-level debounce model.
module tb_switches_poll_ctrl;

  localparam int DATA_W       = 4;
  localparam int ADDR_W       = 2;
  localparam int POLL_DIV     = 4;
  localparam int STABLE_CNT   = 3;
  localparam int READ_LATENCY = 1;
  localparam int PERIOD       = POLL_DIV + READ_LATENCY + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic [DATA_W-1:0] sw_value;
  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic              evt_ready = 1'b0;
  logic              evt_overrun;
  logic              clr_overrun = 1'b0;
  logic [DATA_W-1:0] in_port = '0;
  logic [31:0]       rnd;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_cand, m_cnt, m_sw, m_valid, m_data, m_ov;
  bit pend_valid;
  int pend_age, pend_sample;
  bit have_prev, broke, rd_prev, was_reset;
  int since;
  logic [POLL_DIV-1:0] en_hist;

  typedef struct {
    logic [3:0] din;
    logic [3:0] sw;
    logic       vld;
    logic [3:0] data;
    logic       ov;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  switches_poll_ctrl #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .POLL_DIV     (POLL_DIV),
    .STABLE_CNT   (STABLE_CNT),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .sw_value     (sw_value),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_overrun  (evt_overrun),
    .clr_overrun  (clr_overrun)
  );

  // PIO slave: registered readdata one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    rnd = $urandom;
    avm_readdata <= avm_read ? {rnd[31:DATA_W], in_port} : rnd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advances the model by one clock edge using the values present before it.
  task automatic model_edge();
    bit fire, ov_set;
    int s;
    if (!reset_n) begin
      m_cand = 0; m_cnt = 0; m_sw = 0; m_valid = 0; m_data = 0; m_ov = 0;
      pend_valid = 0; pend_age = 0; pend_sample = 0;
      have_prev = 0; broke = 0; since = 0; en_hist = '0; rd_prev = 0;
      was_reset = 1;
    end else begin
      was_reset = 0;
      if (avm_read) begin
        check("read_addr", 32'(avm_address), 32'd0);
        check("read_single_cycle", 32'(rd_prev), 32'd0);
        check("read_needs_enable", 32'(en_hist == {POLL_DIV{1'b1}}), 32'd1);
        if (have_prev && !broke) check("poll_period", since, PERIOD);
        have_prev = 1; since = 0; broke = 0;
      end
      since++;
      if (!enable) broke = 1;
      en_hist = {en_hist[POLL_DIV-2:0], enable};
      rd_prev = avm_read;

      fire = 0;
      if (pend_valid) begin
        pend_age++;
        if (pend_age == READ_LATENCY + 1) begin
          pend_valid = 0;
          s = pend_sample;
          if (s == m_cand) m_cnt = (m_cnt + 1 > STABLE_CNT) ? STABLE_CNT : m_cnt + 1;
          else begin
            m_cand = s;
            m_cnt  = 1;
          end
          if (m_cnt == STABLE_CNT && m_cand != m_sw) begin
            fire = 1;
            m_sw = m_cand;
          end
        end
      end
      if (avm_read) begin
        pend_valid  = 1;
        pend_age    = 0;
        pend_sample = int'(in_port);
      end

      ov_set = fire && (m_valid != 0) && !evt_ready;
      if (fire) begin
        m_valid = 1;
        m_data  = m_sw;
      end else if (m_valid != 0 && evt_ready) begin
        m_valid = 0;
      end
      if (ov_set) m_ov = 1;
      else if (clr_overrun) m_ov = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("outputs_vs_model",
          {22'd0, sw_value, evt_valid, evt_data, evt_overrun},
          {22'd0, DATA_W'(m_sw), m_valid[0], DATA_W'(m_data), m_ov[0]});
    if (was_reset) check("read_low_after_reset", 32'(avm_read), 32'd0);
  endtask

  task automatic wait_read(output int n);
    n = 0;
    while (!avm_read && n < 200) begin
      step();
      n++;
    end
    if (!avm_read) check("read_timeout", 32'(avm_read), 32'd1);
  endtask

  task automatic poll_and_settle();
    int n;
    wait_read(n);
    repeat (3) step();
  endtask

  function automatic logic [31:0] outs_now();
    return {22'd0, sw_value, evt_valid, evt_data, evt_overrun};
  endfunction

  initial begin
    int lat, reads;
    logic [DATA_W-1:0] base;

    tbl[0]  = '{4'hA, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{4'h5, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{4'hA, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{4'hA, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[4]  = '{4'hA, 4'hA, 1'b1, 4'hA, 1'b0};
    tbl[5]  = '{4'h3, 4'hA, 1'b1, 4'hA, 1'b0};
    tbl[6]  = '{4'h3, 4'hA, 1'b1, 4'hA, 1'b0};
    tbl[7]  = '{4'h3, 4'h3, 1'b1, 4'h3, 1'b1};
    tbl[8]  = '{4'hC, 4'h3, 1'b1, 4'h3, 1'b1};
    tbl[9]  = '{4'hC, 4'h3, 1'b1, 4'h3, 1'b1};
    tbl[10] = '{4'hC, 4'hC, 1'b1, 4'hC, 1'b1};

    // reset with switches high, then time to first read
    in_port = 4'hF;
    enable  = 1'b1;
    reset_n = 1'b0;
    repeat (3) step();
    check("reset_state", {outs_now()[30:0], avm_read}, 32'd0);
    reset_n = 1'b1;
    wait_read(lat);
    check("first_read_latency", lat, POLL_DIV);
    repeat (3) step();

    // debounce and overwrite vectors, one poll per row, consumer stalled
    for (int i = 0; i < 11; i++) begin
      in_port = tbl[i].din;
      poll_and_settle();
      check($sformatf("table_row%0d", i), outs_now(),
            {22'd0, tbl[i].sw, tbl[i].vld, tbl[i].data, tbl[i].ov});
    end

    // clear overrun, then accept the pending event
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("clr_overrun", outs_now(), {22'd0, 4'hC, 1'b1, 4'hC, 1'b0});
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("accept_drops_valid", 32'(evt_valid), 32'd0);

    // steady A for three polls
    in_port = 4'hA;
    poll_and_settle();
    poll_and_settle();
    check("steady_a_two_polls", outs_now(), {22'd0, 4'hC, 1'b0, 4'hC, 1'b0});
    poll_and_settle();
    check("steady_a_event", outs_now(), {22'd0, 4'hA, 1'b1, 4'hA, 1'b0});
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("steady_a_accept", 32'(evt_valid), 32'd0);

    // disable during the read strobe
    wait_read(lat);
    enable = 1'b0;
    repeat (3) step();
    reads = 0;
    repeat (20) begin
      step();
      if (avm_read) reads++;
    end
    check("no_read_when_disabled", reads, 0);
    enable = 1'b1;
    wait_read(lat);
    check("reenable_latency", lat, POLL_DIV);
    repeat (3) step();

    // reset while waiting for readdata
    in_port = 4'h5;
    wait_read(lat);
    step();
    reset_n = 1'b0;
    step();
    check("reset_mid_wait", {outs_now()[30:0], avm_read}, 32'd0);
    reset_n = 1'b1;
    poll_and_settle();
    poll_and_settle();
    check("cnt_restart_two_polls", outs_now(), 32'd0);
    poll_and_settle();
    check("cnt_restart_event", outs_now(), {22'd0, 4'h5, 1'b1, 4'h5, 1'b0});

    // overrun and clear in the same cycle: set wins
    in_port = 4'h9;
    poll_and_settle();
    poll_and_settle();
    wait_read(lat);
    step();
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("overrun_set_wins", outs_now(), {22'd0, 4'h9, 1'b1, 4'h9, 1'b1});

    // randomized traffic against the model
    base = 4'h0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 29) == 0) base = DATA_W'($urandom_range(0, 15));
      in_port     = ($urandom_range(0, 9) == 0) ? DATA_W'($urandom_range(0, 15)) : base;
      evt_ready   = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      enable      = ($urandom_range(0, 49) != 0);
      reset_n     = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
